vx_writeback_arb: RTL and testbench

- Packet-aware N-to-1 arbiter for writeback traffic: merges several functional-unit writeback streams onto one writeback port ahead of the register file.
- Unlike a plain valid/data writeback port, it adds ready backpressure, round-robin fairness and a 2-entry output buffer.
- Keeps multi-beat packets contiguous: beats from sop through eop (e.g. vector lane sequences) are never interleaved with other sources.

---
 rtl/VX_gpu_pkg.sv | 22 ++
 rtl/vx_wb_skid_buf.sv | 47 ++++
 rtl/vx_writeback_arb.sv | 88 ++++++++
 tb/tb_vx_writeback_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared GPU types: the writeback beat carried from functional units to the
// register file, and the writeback arbiter state encoding.
package VX_gpu_pkg;

  typedef struct packed {
    logic [3:0]  wid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } data_t;

  // Bit positions of the framing flags inside a flattened data_t.
  localparam int WB_EOP_BIT = 0;
  localparam int WB_SOP_BIT = 1;

  typedef enum logic {
    WB_ARB_IDLE,
    WB_ARB_LOCKED
  } wb_arb_state_e;

endpackage

// File: rtl/vx_wb_skid_buf.sv
// 2-entry registered FIFO with valid/ready handshakes; full is derived from
// the registered count only, so in_ready never depends on out_ready.
module vx_wb_skid_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0][DATAW-1:0] mem;
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count;
  logic                  enq, deq;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vx_writeback_arb.sv
// Packet-aware round-robin N-to-1 writeback arbiter; a source that starts a
// multi-beat packet keeps the grant until its eop beat is accepted.
module vx_writeback_arb
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS   = 4,
  parameter int DATAW        = $bits(data_t),
  parameter bit LOCK_PACKETS = 1'b1,
  localparam int SELW        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATAW-1:0]                 out_data,
  output logic [SELW-1:0]                  out_sel,
  input  logic                             out_ready,
  output logic                             locked
);

  wb_arb_state_e    state;
  logic [SELW-1:0]  ptr, owner, grant, ptr_nxt, cidx;
  logic             cand_valid, buf_ready, accept, eop;
  int               idx;

  // Round-robin search from ptr while idle; only the owner competes while locked.
  always_comb begin
    grant      = owner;
    cand_valid = in_valid[owner];
    idx        = 0;
    cidx       = '0;
    if (state == WB_ARB_IDLE) begin
      grant      = ptr;
      cand_valid = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        cidx = SELW'(idx);
        if (!cand_valid && in_valid[cidx]) begin
          cand_valid = 1'b1;
          grant      = cidx;
        end
      end
    end
  end

  assign accept  = cand_valid && buf_ready && !reset;
  assign eop     = in_data[grant][WB_EOP_BIT];
  assign ptr_nxt = (grant == SELW'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
  assign locked  = (state == WB_ARB_LOCKED);

  always_comb begin
    in_ready        = '0;
    in_ready[grant] = accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WB_ARB_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else if (accept) begin
      if (LOCK_PACKETS && !eop) begin
        state <= WB_ARB_LOCKED;
        owner <= grant;
      end else begin
        state <= WB_ARB_IDLE;
        ptr   <= ptr_nxt;
      end
    end
  end

  vx_wb_skid_buf #(
    .DATAW (DATAW + SELW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   ({in_data[grant], grant}),
    .in_ready  (buf_ready),
    .out_valid (out_valid),
    .out_data  ({out_data, out_sel}),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Directed scoreboard bench for vx_writeback_arb: one packet-locking instance
// and one per-beat round-robin instance share the clock.
module tb_vx_writeback_arb;
  import VX_gpu_pkg::*;

  localparam int N  = 4;
  localparam int DW = $bits(data_t);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         iv0, iv1, ir0, ir1;
  logic [N-1:0][DW-1:0] id0, id1;
  logic                 ov0, ov1, or0, or1, lk0, lk1;
  logic [DW-1:0]        od0, od1;
  logic [1:0]           os0, os1;

  vx_writeback_arb #(.NUM_INPUTS(N), .LOCK_PACKETS(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(or0), .locked(lk0));

  vx_writeback_arb #(.NUM_INPUTS(N), .LOCK_PACKETS(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(or1), .locked(lk1));

  typedef struct {
    logic [1:0]    sel;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   checks = 0, errors = 0, tid = 0;
  int   left[2][N], plen[2][N], seq[2][N];
  bit   hold[2][N];
  logic [N-1:0]  acc0, acc1;
  logic          ov_s, lk_s, lk1_s;
  logic [DW-1:0] od_s;

  logic [3:0] t2_acc [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
  logic       t2_lk  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0] t3_acc [9] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0010, 4'b0100, 4'b0000};
  logic [3:0] t4_acc [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
  logic [3:0] t6_acc [4] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100};

  function automatic logic [DW-1:0] mk(int src, int s, int pl);
    data_t b;
    b.wid  = 4'(src);
    b.rd   = 5'(s);
    b.data = 32'(tid * 4096 + src * 256 + s);
    b.sop  = ((s % pl) == 0);
    b.eop  = ((s % pl) == pl - 1);
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      iv0[i] = (left[0][i] > 0) && !hold[0][i];
      iv1[i] = (left[1][i] > 0) && !hold[1][i];
      id0[i] = mk(i, seq[0][i], plen[0][i]);
      id1[i] = mk(i, seq[1][i], plen[1][i]);
    end
  endtask

  task automatic setsrc(int d, int i, int nleft, int pl);
    left[d][i] = nleft;
    plen[d][i] = pl;
    seq[d][i]  = 0;
    hold[d][i] = 1'b0;
  endtask

  task automatic push(int d, int src, int s, int pl);
    exp_t e;
    e.sel = 2'(src);
    e.d   = mk(src, s, pl);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Sample on the falling edge, let the rising edge transfer, then advance sources.
  task automatic tick();
    @(negedge clk);
    acc0  = iv0 & ir0;
    acc1  = iv1 & ir1;
    ov_s  = ov0;
    lk_s  = lk0;
    lk1_s = lk1;
    od_s  = od0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc0[i]) begin seq[0][i]++; left[0][i]--; end
      if (acc1[i]) begin seq[1][i]++; left[1][i]--; end
    end
    drive();
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output monitor: every output transfer must match the head of its queue.
  always @(negedge clk) begin
    if (!reset && ov0 && or0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL mon0_unexpected: got sel %0d data %0h expected none", os0, od0);
      end else begin
        e0 = q0.pop_front();
        if (os0 !== e0.sel || od0 !== e0.d) begin
          errors++;
          $display("FAIL mon0_beat: got sel %0d data %0h expected sel %0d data %0h",
                   os0, od0, e0.sel, e0.d);
        end
      end
    end
    if (!reset && ov1 && or1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL mon1_unexpected: got sel %0d data %0h expected none", os1, od1);
      end else begin
        e1 = q1.pop_front();
        if (os1 !== e1.sel || od1 !== e1.d) begin
          errors++;
          $display("FAIL mon1_beat: got sel %0d data %0h expected sel %0d data %0h",
                   os1, od1, e1.sel, e1.d);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) setsrc(d, i, 0, 1);
    or0 = 1'b1;
    or1 = 1'b1;
    drive();

    // Reset state
    @(negedge clk);
    chk("reset_out_valid", ov0, 0);
    chk("reset_locked", lk0, 0);
    chk("reset_in_ready", ir0, 0);
    chk("reset_out_data", od0, 0);
    chk("reset_out_sel", os0, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single beats, all sources valid: 0,1,2,3,0 at one per cycle
    tid = 1;
    setsrc(0, 0, 2, 1);
    for (int i = 1; i < N; i++) setsrc(0, i, 1, 1);
    drive();
    push(0, 0, 0, 1); push(0, 1, 0, 1); push(0, 2, 0, 1); push(0, 3, 0, 1); push(0, 0, 1, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t1_grant", acc0, 4'b0001 << (c % 4));
      chk("t1_out_valid", ov_s, (c > 0));
    end
    tick(); tick();
    chk("t1_drained", q0.size(), 0);

    // 3-beat packet from input 1 holds off input 2
    tid = 2;
    setsrc(0, 1, 3, 3);
    setsrc(0, 2, 2, 1);
    drive();
    push(0, 1, 0, 3); push(0, 1, 1, 3); push(0, 1, 2, 3); push(0, 2, 0, 1); push(0, 2, 1, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t2_grant", acc0, t2_acc[c]);
      chk("t2_locked", lk_s, t2_lk[c]);
    end
    tick(); tick();
    chk("t2_drained", q0.size(), 0);

    // Output stall: two beats buffered, then backpressure, then in-order drain
    tid = 3;
    or0 = 1'b0;
    for (int i = 0; i < N; i++) setsrc(0, i, 1, 1);
    drive();
    push(0, 3, 0, 1); push(0, 0, 0, 1); push(0, 1, 0, 1); push(0, 2, 0, 1);
    for (int c = 0; c < 9; c++) begin
      tick();
      chk("t3_grant", acc0, t3_acc[c]);
      if (c >= 2 && c <= 4) begin
        chk("t3_hold_valid", ov_s, 1);
        chk("t3_hold_data", od_s, mk(3, 0, 1));
      end
      if (c == 4) or0 = 1'b1;
    end
    tick();
    chk("t3_drained", q0.size(), 0);

    // Per-beat round-robin ignores eop: 0,3,0,3 with no lock
    tid = 4;
    setsrc(1, 0, 2, 4);
    setsrc(1, 3, 2, 4);
    drive();
    push(1, 0, 0, 4); push(1, 3, 0, 4); push(1, 0, 1, 4); push(1, 3, 1, 4);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t4_grant", acc1, t4_acc[c]);
      chk("t4_locked", lk1_s, 0);
    end
    tick(); tick();
    chk("t4_drained", q1.size(), 0);
    chk("t4_locked_end", lk1, 0);

    // Reset mid-packet with two beats buffered
    tid = 5;
    or0 = 1'b0;
    setsrc(0, 2, 4, 4);
    drive();
    tick(); chk("t5_grant_a", acc0, 4'b0100);
    tick(); chk("t5_grant_b", acc0, 4'b0100);
    chk("t5_locked_pre", lk0, 1);
    chk("t5_full_valid", ov0, 1);
    reset = 1'b1;
    setsrc(0, 2, 0, 4);
    setsrc(0, 1, 1, 1);
    setsrc(0, 3, 1, 1);
    or0 = 1'b1;
    drive();
    chk("t5_ready_in_reset", ir0, 0);
    tick();
    chk("t5_out_valid_rst", ov_s, 0);
    chk("t5_locked_rst", lk_s, 0);
    reset = 1'b0;
    push(0, 1, 0, 1); push(0, 3, 0, 1);
    tick(); chk("t5_first_grant", acc0, 4'b0010);
    tick(); chk("t5_second_grant", acc0, 4'b1000);
    tick(); tick();
    chk("t5_drained", q0.size(), 0);

    // Owner stalls mid-packet; nobody else is granted until its eop
    tid = 6;
    setsrc(0, 0, 3, 3);
    setsrc(0, 1, 1, 1);
    setsrc(0, 2, 1, 1);
    drive();
    push(0, 0, 0, 3); push(0, 0, 1, 3); push(0, 0, 2, 3); push(0, 1, 0, 1); push(0, 2, 0, 1);
    tick(); chk("t6_first", acc0, 4'b0001);
    hold[0][0] = 1'b1;
    drive();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_stall_grant", acc0, 4'b0000);
      chk("t6_stall_locked", lk_s, 1);
    end
    hold[0][0] = 1'b0;
    drive();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_resume_grant", acc0, t6_acc[c]);
    end
    tick(); tick();
    chk("t6_drained", q0.size(), 0);
    chk("t6_unlocked", lk0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
